// File: rtl/led_fpga.sv
// led_fpga
// Board-level user interface for the LED demo. Four debounced push-buttons
// step a 0..10 level up and down, cycle the display mode and invert the bar.
// A one-hot indicator on segments shows the active display mode.
//
// Ports:
//   clk       system clock (50 MHz on the board), all state on rising edge
//   button    board keys; button[0] is the asynchronous active-low reset,
//             button[1] level up, button[2] level down,
//             button[3] mode cycle, button[4] invert toggle
//   LEDs      registered LED drive, 1 = lit
//   segments  registered one-hot mode indicator (BAR=001, DOT=010, BIN=100)
module led_fpga #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic [4:0] button,
  output logic [9:0] LEDs,
  output logic [2:0] segments
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    BAR = 2'd0,
    DOT = 2'd1,
    BIN = 2'd2
  } mode_t;

  logic       rst_n;
  logic [1:0] rst_pipe;
  logic       sys_rst_n;

  logic [3:0]    sync_a;
  logic [3:0]    sync_b;
  logic [3:0]    deb;
  logic [3:0]    deb_d;
  logic [CW-1:0] cnt [4];
  logic [3:0]    press;

  logic [3:0] level;
  mode_t      mode;
  logic       invert;
  logic [9:0] pattern;

  assign rst_n = button[0];

  // Reset asserts immediately but releases only after two clean clock edges,
  // so the rest of the design never leaves reset on a metastable edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign sys_rst_n = rst_pipe[1];

  // Per-button synchroniser and debounce counter. The counter only runs
  // while the synced input disagrees with the accepted level, so any bounce
  // back to the accepted level restarts the full debounce window.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      deb_d  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_a <= button[4:1];
      sync_b <= sync_a;
      deb_d  <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] != deb[i]) begin
          if (cnt[i] == CNT_LAST) begin
            deb[i] <= sync_b[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // One-cycle pulse on each rising edge of a debounced level; releases are ignored.
  assign press = deb & ~deb_d;

  // Level, mode and invert state. Up and down together cancel; pulses on
  // different functions in the same cycle all take effect.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level  <= 4'd0;
      mode   <= BAR;
      invert <= 1'b0;
    end else begin
      if (press[0] && !press[1] && level != 4'd10) begin
        level <= level + 4'd1;
      end else if (press[1] && !press[0] && level != 4'd0) begin
        level <= level - 4'd1;
      end
      if (press[2]) begin
        case (mode)
          BAR:     mode <= DOT;
          DOT:     mode <= BIN;
          default: mode <= BAR;
        endcase
      end
      if (press[3]) begin
        invert <= ~invert;
      end
    end
  end

  // LED pattern for the current mode, before inversion.
  always_comb begin
    pattern = '0;
    case (mode)
      BAR: begin
        for (int k = 0; k < 10; k++) begin
          pattern[k] = (4'(k) < level);
        end
      end
      DOT: begin
        for (int k = 0; k < 10; k++) begin
          pattern[k] = (4'(k + 1) == level);
        end
      end
      default: pattern = {6'b000000, level};
    endcase
  end

  // Registered outputs, one cycle behind the state registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      LEDs     <= 10'h000;
      segments <= 3'b001;
    end else begin
      LEDs <= invert ? ~pattern : pattern;
      case (mode)
        BAR:     segments <= 3'b001;
        DOT:     segments <= 3'b010;
        default: segments <= 3'b100;
      endcase
    end
  end

endmodule

// File: tb/tb_led_fpga.sv
// tb_led_fpga
// Testbench for led_fpga with a short debounce window. Directed steps walk
// through reset, bounce, saturation, modes, inversion and reset mid-press,
// followed by random button combinations checked against a behavioural model.
module tb_led_fpga;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic [4:0] button;
  logic [9:0] LEDs;
  logic [2:0] segments;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: level as a number, mode 0=BAR 1=DOT 2=BIN.
  int m_level = 0;
  int m_mode  = 0;
  bit m_inv   = 1'b0;

  always #10 clk = ~clk;

  led_fpga #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk      (clk),
    .button   (button),
    .LEDs     (LEDs),
    .segments (segments)
  );

  function automatic logic [9:0] model_leds();
    int p;
    case (m_mode)
      0:       p = (1 << m_level) - 1;
      1:       p = (m_level == 0) ? 0 : (1 << (m_level - 1));
      default: p = m_level;
    endcase
    if (m_inv) p = ~p;
    return 10'(p & 'h3FF);
  endfunction

  function automatic logic [2:0] model_segs();
    return 3'(1 << m_mode);
  endfunction

  task automatic model_reset();
    m_level = 0;
    m_mode  = 0;
    m_inv   = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_value(input string tag, input logic [9:0] exp_leds,
                             input logic [2:0] exp_segs);
    checks++;
    assert (LEDs === exp_leds) else begin
      errors++;
      $error("[TB] FAIL %s LEDs: got %h expected %h", tag, LEDs, exp_leds);
    end
    checks++;
    assert (segments === exp_segs) else begin
      errors++;
      $error("[TB] FAIL %s segments: got %b expected %b", tag, segments, exp_segs);
    end
  endtask

  task automatic check_output(input string tag);
    check_value(tag, model_leds(), model_segs());
  endtask

  // Clean press and release of the buttons in mask (bit 0 = button[1]).
  task automatic apply_stimulus(input logic [3:0] mask, input string tag);
    button = {mask, 1'b1};
    cyc(DEB + 8);
    button = 5'b00001;
    cyc(DEB + 8);
    if (mask[0] && !mask[1] && m_level < 10) m_level++;
    else if (mask[1] && !mask[0] && m_level > 0) m_level--;
    if (mask[2]) m_mode = (m_mode + 1) % 3;
    if (mask[3]) m_inv = !m_inv;
    check_output(tag);
  endtask

  task automatic bounce(input int toggles);
    for (int i = 0; i < toggles; i++) begin
      #50 button[1] = ~button[1];
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] mask;

    // Reset held, then released for 100 cycles.
    button = 5'b00000;
    cyc(5);
    check_value("reset_hold", 10'h000, 3'b001);
    button = 5'b00001;
    for (int i = 0; i < 10; i++) begin
      cyc(10);
      check_value("reset_release", 10'h000, 3'b001);
    end

    // Bounced press: exactly one increment, timed from the last toggle.
    $display("[TB] bounced press");
    bounce(99);
    cyc(DEB - 4);
    check_output("bounce_early");
    cyc(12);
    m_level = 1;
    check_output("bounce_press");
    check_value("bounce_const", 10'h001, 3'b001);
    bounce(99);
    cyc(DEB + 10);
    check_output("bounce_release");

    // Saturation at both ends.
    $display("[TB] saturation");
    for (int i = 0; i < 12; i++) apply_stimulus(4'b0001, "sat_up");
    check_value("sat_top", 10'h3FF, 3'b001);
    for (int i = 0; i < 12; i++) apply_stimulus(4'b0010, "sat_down");
    check_value("sat_bottom", 10'h000, 3'b001);

    // Modes at level 5.
    $display("[TB] modes");
    for (int i = 0; i < 5; i++) apply_stimulus(4'b0001, "to_level5");
    check_value("mode_bar", 10'h01F, 3'b001);
    apply_stimulus(4'b0100, "mode_step");
    check_value("mode_dot", 10'h010, 3'b010);
    apply_stimulus(4'b0100, "mode_step");
    check_value("mode_bin", 10'h005, 3'b100);
    apply_stimulus(4'b0100, "mode_step");
    check_value("mode_wrap", 10'h01F, 3'b001);

    // Invert and simultaneous presses.
    $display("[TB] invert and simultaneous");
    apply_stimulus(4'b0010, "to_level3");
    apply_stimulus(4'b0010, "to_level3");
    apply_stimulus(4'b1000, "invert");
    check_value("invert_l3", 10'h3F8, 3'b001);
    apply_stimulus(4'b0011, "up_down");
    check_value("up_down_const", 10'h3F8, 3'b001);
    apply_stimulus(4'b0101, "mode_up");
    check_value("mode_up_const", 10'h3F7, 3'b010);

    // Short glitch produces nothing.
    $display("[TB] glitch and reset mid-press");
    button = 5'b00011;
    cyc(DEB / 2);
    button = 5'b00001;
    cyc(DEB + 10);
    check_output("short_glitch");

    // Reset during a partial press clears everything immediately.
    button = 5'b00011;
    cyc(DEB * 8 / 10);
    button = 5'b00000;
    #1;
    model_reset();
    check_output("reset_mid_press");
    cyc(3);
    button = 5'b00001;
    cyc(DEB + 10);
    check_output("after_mid_reset");
    check_value("after_mid_reset_const", 10'h000, 3'b001);

    // Button held through reset release counts as one press.
    button = 5'b00010;
    cyc(3);
    button = 5'b00011;
    cyc(DEB + 10);
    m_level = 1;
    check_output("held_through_reset");
    button = 5'b00001;
    cyc(DEB + 10);
    check_output("held_release");

    // Random button combinations.
    $display("[TB] random presses");
    for (int i = 0; i < 25; i++) begin
      mask = 4'($urandom_range(1, 15));
      apply_stimulus(mask, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
